// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned PC_INC_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    OUT,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/pc_reg_param.sv
// Program-counter register: synchronous reset to RESET_PC, loads d when en is high.
module pc_reg_param #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC sequencing, single-outstanding memory handshake,
// redirect with in-flight kill, and a valid/ready hold register towards decode.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ADDR_W   = ADDR_W_DEF,
  parameter int unsigned     PC_INC   = PC_INC_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              m_req,
  output logic [ADDR_W-1:0] m_addr,
  input  logic              m_ack,
  input  logic [XLEN-1:0]   m_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [XLEN-1:0]   inst_data,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   pc_q
);

  fetch_state_e    state;
  logic            pc_en;
  logic [XLEN-1:0] pc_d;

  // Redirect wins over the sequential step taken on a decode handshake.
  always_comb begin
    pc_en = redirect_valid || ((state == OUT) && inst_ready);
    pc_d  = pc_q + XLEN'(PC_INC);
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
    end
  end

  pc_reg_param #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_d),
    .q   (pc_q)
  );

  assign m_addr = pc_q[ADDR_W+1:2];

  // Fetch FSM; DRAIN is the kill state that swallows the response to a redirected request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m_req      <= 1'b0;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fetch_en) begin
            state <= REQ;
            m_req <= 1'b1;
          end
        end
        REQ: begin
          if (redirect_valid && !m_ack) begin
            state <= DRAIN;
            m_req <= 1'b0;
          end else if (redirect_valid) begin
            // Response arrived for the stale address; re-request at the new PC.
            state <= REQ;
          end else if (m_ack) begin
            state      <= OUT;
            m_req      <= 1'b0;
            inst_valid <= 1'b1;
            inst_data  <= m_data;
            inst_pc    <= pc_q;
          end
        end
        OUT: begin
          if (redirect_valid || inst_ready) begin
            inst_valid <= 1'b0;
            state      <= fetch_en ? REQ : IDLE;
            m_req      <= fetch_en;
          end
        end
        DRAIN: begin
          if (m_ack) begin
            state <= fetch_en ? REQ : IDLE;
            m_req <= fetch_en;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a transaction-level fetch model and memory model.
module tb_pc_fetch_unit;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 5;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam int          NCYC   = 4000;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetch_en;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_ack;
  logic [XLEN-1:0]   m_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [XLEN-1:0]   inst_data;
  logic [XLEN-1:0]   inst_pc;
  logic [XLEN-1:0]   pc_q;

  pc_fetch_unit #(
    .XLEN     (XLEN),
    .ADDR_W   (ADDR_W),
    .PC_INC   (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .m_req          (m_req),
    .m_addr         (m_addr),
    .m_ack          (m_ack),
    .m_data         (m_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .pc_q           (pc_q)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory contents: a distinct word per word address.
  function automatic logic [31:0] mem_word(input logic [4:0] a);
    return 32'hC0DE_0000 + 32'(a) * 32'h0000_1001;
  endfunction

  // Reference state: architectural next PC plus the previous cycle's inputs/outputs.
  logic [31:0] exp_pc;
  logic        prev_rst, prev_redir, prev_valid, prev_ready, prev_req, prev_ack;
  logic [31:0] prev_tgt;
  logic        mem_busy;
  logic [4:0]  mem_addr;
  int          mem_cnt;
  int          n_acc;

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    m_ack = 1'b0; m_data = '0; inst_ready = 1'b0;
    exp_pc = RST_PC; prev_rst = 1'b1; prev_redir = 1'b0; prev_tgt = '0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
    mem_busy = 1'b0; mem_addr = '0; mem_cnt = 0; n_acc = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (prev_rst) begin
        exp_pc = RST_PC;
      end else if (prev_redir) begin
        exp_pc = prev_tgt & ~32'h3;
      end else if (prev_valid && prev_ready) begin
        exp_pc = exp_pc + 32'd4;
        n_acc++;
      end

      if (prev_rst) begin
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_data", inst_data, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
      end
      check("pc_q", pc_q, exp_pc);
      if (m_req) check("m_addr", 32'(m_addr), 32'(exp_pc[6:2]));
      if (!prev_rst) begin
        if (prev_redir || (prev_valid && prev_ready)) check("squash_or_consume", 32'(inst_valid), 32'd0);
        else if (prev_valid) check("valid_hold", 32'(inst_valid), 32'd1);
        if (prev_req && prev_ack && !prev_redir) check("ack_to_valid", 32'(inst_valid), 32'd1);
        if (prev_req && !prev_ack && !prev_redir) check("req_hold", 32'(m_req), 32'd1);
      end
      if (inst_valid) begin
        check("inst_pc", inst_pc, exp_pc);
        check("inst_data", inst_data, mem_word(exp_pc[6:2]));
      end

      // Drive inputs for the next edge.
      rst            = (cyc < 2) || ($urandom_range(0, 199) == 0);
      fetch_en       = ($urandom_range(0, 99) < 85);
      redirect_valid = ($urandom_range(0, 99) < 7);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF4 + 32'($urandom_range(0, 11));
      else redirect_pc = $urandom;
      inst_ready     = ($urandom_range(0, 99) < 60);

      // Memory: one request at a time, 0..3 cycles to respond, occasional stray acks when idle.
      if (rst) begin
        mem_busy = 1'b0;
        m_ack    = 1'b0;
        m_data   = $urandom;
      end else begin
        if (!mem_busy && m_req) begin
          mem_busy = 1'b1;
          mem_addr = m_addr;
          mem_cnt  = $urandom_range(0, 3);
        end
        if (mem_busy) begin
          if (mem_cnt == 0) begin
            m_ack    = 1'b1;
            m_data   = mem_word(mem_addr);
            mem_busy = 1'b0;
          end else begin
            mem_cnt--;
            m_ack  = 1'b0;
            m_data = $urandom;
          end
        end else begin
          m_ack  = !m_req && ($urandom_range(0, 19) == 0);
          m_data = $urandom;
        end
      end

      prev_rst   = rst;
      prev_redir = redirect_valid;
      prev_tgt   = redirect_pc;
      prev_valid = inst_valid;
      prev_ready = inst_ready;
      prev_req   = m_req;
      prev_ack   = m_ack;
    end

    check("progress", 32'(n_acc > 100), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
